// File: rtl/bsg_chip_reset_sequencer_if.sv
// Request/reset bundle between the tag clients (master) and the reset
// sequencer (slave).
interface bsg_chip_reset_sequencer_if #(
  parameter int num_channels_p = 4
);

  logic [num_channels_p-1:0] req_v_i;
  logic [num_channels_p-1:0] req_reset_i;
  logic [num_channels_p-1:0] reset_o;
  logic                      busy_o;
  logic                      done_o;

  modport master (
    output req_v_i,
    output req_reset_i,
    input  reset_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  req_v_i,
    input  req_reset_i,
    output reset_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/bsg_chip_reset_sequencer.sv
// Ordered reset release for N tag-driven channels: assertion is immediate,
// deassertion walks upward from channel 0 with a minimum hold between steps.
module bsg_chip_reset_sequencer #(
  parameter int num_channels_p = 4,
  parameter int hold_cycles_p  = 16
) (
  input logic                       clk_i,
  input logic                       reset_i,
  bsg_chip_reset_sequencer_if.slave io
);

  localparam int cnt_width_lp = $clog2(hold_cycles_p+1);

  typedef enum logic {
    e_stable,
    e_wait
  } state_e;

  state_e                    state_r, state_n;
  logic [num_channels_p-1:0] req_r;
  logic [num_channels_p-1:0] reset_r, reset_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;

  logic [num_channels_p-1:0] eff;
  logic [num_channels_p-1:0] cand_mask;
  logic [num_channels_p-1:0] cand_oh;
  logic [num_channels_p-1:0] cand_rest;
  logic                      assert_pend;
  logic                      cand_v;
  logic                      cnt_sat;

  // A channel is held in reset while it or any upstream channel is requested.
  always_comb begin
    eff    = '0;
    eff[0] = req_r[0];
    for (int i = 1; i < num_channels_p; i++) begin
      eff[i] = eff[i-1] | req_r[i];
    end
  end

  assign assert_pend = |(eff & ~reset_r);
  assign cand_mask   = reset_r & ~eff;
  assign cand_oh     = cand_mask & (~cand_mask + 1'b1);
  assign cand_rest   = cand_mask & ~cand_oh;
  assign cand_v      = |cand_mask;
  assign cnt_sat     = (cnt_r == cnt_width_lp'(hold_cycles_p));

  // Release may fire straight from STABLE when the counter is already
  // saturated, so the first step out of all-ones costs no extra cycle.
  always_comb begin
    reset_n = reset_r;
    state_n = state_r;
    if (assert_pend) begin
      reset_n = reset_r | eff;
      state_n = cand_v ? e_wait : e_stable;
    end else if (cand_v && cnt_sat) begin
      reset_n = reset_r & ~cand_oh;
      state_n = (|cand_rest) ? e_wait : e_stable;
    end else begin
      state_n = cand_v ? e_wait : e_stable;
    end
  end

  always_comb begin
    cnt_n = cnt_r;
    if (reset_n != reset_r) begin
      cnt_n = '0;
    end else if (!cnt_sat) begin
      cnt_n = cnt_r + cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_r   <= '1;
      reset_r <= '1;
      cnt_r   <= '0;
      state_r <= e_stable;
    end else begin
      req_r   <= (req_r & ~io.req_v_i) | (io.req_reset_i & io.req_v_i);
      reset_r <= reset_n;
      cnt_r   <= cnt_n;
      state_r <= state_n;
    end
  end

  assign io.reset_o = reset_r;
  assign io.busy_o  = (state_r == e_wait);
  assign io.done_o  = ~(|reset_r);

endmodule

// File: tb/tb_bsg_chip_reset_sequencer.sv
// Scoreboard bench for three sequencer configurations (4/16, 1/1, 8/3) driven
// in lockstep against a release-level reference model.
module tb_bsg_chip_reset_sequencer;

  typedef struct packed {
    logic [7:0] rst;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic reset_i;

  bsg_chip_reset_sequencer_if #(.num_channels_p(4)) if0 ();
  bsg_chip_reset_sequencer_if #(.num_channels_p(1)) if1 ();
  bsg_chip_reset_sequencer_if #(.num_channels_p(8)) if2 ();

  bsg_chip_reset_sequencer #(.num_channels_p(4), .hold_cycles_p(16)) u0 (
    .clk_i(clk), .reset_i(reset_i), .io(if0));
  bsg_chip_reset_sequencer #(.num_channels_p(1), .hold_cycles_p(1)) u1 (
    .clk_i(clk), .reset_i(reset_i), .io(if1));
  bsg_chip_reset_sequencer #(.num_channels_p(8), .hold_cycles_p(3)) u2 (
    .clk_i(clk), .reset_i(reset_i), .io(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cfg [3] = '{4, 1, 8};
  int h_cfg [3] = '{16, 1, 3};

  // Model state: m_k is the number of channels currently out of reset.
  logic [7:0] m_req  [3];
  int         m_k    [3];
  int         m_cnt  [3];
  bit         m_busy [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [7:0] prev_rst [3] = '{8'hff, 8'hff, 8'hff};
  int         last_chg [3] = '{-100, -100, -100};

  function automatic logic [7:0] mask_of(int n);
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic [7:0] rand_strobe(int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = ($urandom_range(0, 7) == 0);
    return v;
  endfunction

  function automatic logic [7:0] rand_value(int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = ($urandom_range(0, 2) == 0);
    return v;
  endfunction

  task automatic model_step(int idx, bit rst, logic [7:0] v, logic [7:0] r);
    int   n = n_cfg[idx];
    int   h = h_cfg[idx];
    int   f;
    int   k;
    int   k_nx;
    bit   asrt;
    bit   rel;
    exp_t e;
    logic [7:0] mask = mask_of(n);
    if (rst) begin
      m_req[idx]  = mask;
      m_k[idx]    = 0;
      m_cnt[idx]  = 0;
      m_busy[idx] = 1'b0;
    end else begin
      k = m_k[idx];
      f = n;
      for (int i = n - 1; i >= 0; i--) if (m_req[idx][i]) f = i;
      asrt = (f < k);
      rel  = !asrt && (k < f) && (m_cnt[idx] == h);
      k_nx = asrt ? f : (rel ? k + 1 : k);
      m_busy[idx] = rel ? (k + 1 < f) : (!asrt && (k < f));
      m_cnt[idx]  = (k_nx != k) ? 0 : ((m_cnt[idx] < h) ? m_cnt[idx] + 1 : h);
      m_k[idx]    = k_nx;
      m_req[idx]  = ((m_req[idx] & ~v) | (r & v)) & mask;
    end
    e.rst  = mask & ~mask_of(m_k[idx]);
    e.busy = m_busy[idx];
    e.done = (m_k[idx] == n);
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic apply_stimulus(bit rst, logic [3:0] v0, logic [3:0] r0);
    logic [7:0] v1 = rand_strobe(1);
    logic [7:0] r1 = rand_value(1);
    logic [7:0] v2 = rand_strobe(8);
    logic [7:0] r2 = rand_value(8);
    @(posedge clk);
    #1;
    reset_i         = rst;
    if0.req_v_i     = v0;
    if0.req_reset_i = r0;
    if1.req_v_i     = v1[0];
    if1.req_reset_i = r1[0];
    if2.req_v_i     = v2;
    if2.req_reset_i = r2;
    model_step(0, rst, {4'b0, v0}, {4'b0, r0});
    model_step(1, rst, v1, r1);
    model_step(2, rst, v2, r2);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 4'b0, 4'b0);
  endtask

  task automatic check_output(int idx, logic [7:0] act_rst, logic act_busy, logic act_done);
    exp_t e;
    logic [7:0] mask = mask_of(n_cfg[idx]);
    case (idx)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    checks++;
    if ({act_rst, act_busy, act_done} === {e.rst, e.busy, e.done}) passes++;
    else $display("[TB] FAIL outputs inst%0d cyc%0d: reset_o=%b busy=%b done=%b, required reset_o=%b busy=%b done=%b",
                  idx, cyc, act_rst, act_busy, act_done, e.rst, e.busy, e.done);
    checks++;
    if (((act_rst << 1) & mask & ~act_rst) == 8'h00) passes++;
    else $display("[TB] FAIL thermometer inst%0d cyc%0d: reset_o=%b, required a thermometer code",
                  idx, cyc, act_rst);
    if (act_rst !== prev_rst[idx]) begin
      if ((act_rst & ~prev_rst[idx]) == 8'h00) begin
        checks++;
        if (cyc - last_chg[idx] >= h_cfg[idx] + 1) passes++;
        else $display("[TB] FAIL spacing inst%0d cyc%0d: gap=%0d, required >= %0d",
                      idx, cyc, cyc - last_chg[idx], h_cfg[idx] + 1);
      end
      last_chg[idx] = cyc;
      prev_rst[idx] = act_rst;
    end
  endtask

  // Each queue holds the entry for the state just presented plus the one for
  // the next edge, so only pop once two are present.
  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 1) check_output(0, {4'b0, if0.reset_o}, if0.busy_o, if0.done_o);
    if (q1.size() > 1) check_output(1, {7'b0, if1.reset_o}, if1.busy_o, if1.done_o);
    if (q2.size() > 1) check_output(2, if2.reset_o, if2.busy_o, if2.done_o);
  end

  initial begin
    int waited;
    reset_i         = 1'b1;
    if0.req_v_i     = '0;
    if0.req_reset_i = '0;
    if1.req_v_i     = '0;
    if1.req_reset_i = '0;
    if2.req_v_i     = '0;
    if2.req_reset_i = '0;

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'b0, 4'b0);
    idle(40);

    apply_stimulus(1'b0, 4'b1111, 4'b0000);
    idle(60);

    apply_stimulus(1'b0, 4'b1111, 4'b1111);
    idle(25);
    apply_stimulus(1'b0, 4'b0100, 4'b0000);
    idle(30);
    apply_stimulus(1'b0, 4'b0011, 4'b0000);
    idle(70);

    apply_stimulus(1'b0, 4'b1111, 4'b1111);
    idle(25);
    apply_stimulus(1'b0, 4'b1111, 4'b1100);
    idle(40);
    apply_stimulus(1'b0, 4'b0010, 4'b0010);
    idle(5);
    apply_stimulus(1'b0, 4'b0010, 4'b0000);
    idle(30);

    apply_stimulus(1'b0, 4'b1100, 4'b0000);
    waited = 0;
    while (!(m_k[0] == 3 && m_busy[0]) && waited < 200) begin
      idle(1);
      waited++;
    end
    checks++;
    if (waited < 200) passes++;
    else $display("[TB] FAIL reach_1000 inst0: waited %0d cycles, required reaching reset_o=1000 with busy", waited);
    apply_stimulus(1'b1, 4'b1111, 4'b0000);
    idle(40);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] v = rand_strobe(4);
      logic [7:0] r = rand_value(4);
      apply_stimulus(1'b0, v[3:0], r[3:0]);
    end
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_chip_reset_sequencer.md
# bsg_chip_reset_sequencer

Parametrised successor to the per-domain tag reset clients in the chip core complex. The block takes N channels of tag-delivered reset requests (the `reset` bit of each `bsg_tag_client` payload plus its new-data strobe) and produces N ordered reset outputs in one clock domain. Assertion is immediate and propagates downstream. Deassertion is sequenced from channel 0 upward, with a programmable hold gap between stages. It sits between the tag clients and the HB/router/IO reset fan-out, so that downstream domains never leave reset before upstream ones.

## Interface
- `num_channels_p`, default 4: number of reset channels; must be ≥1. Channel 0 is most upstream.
- `hold_cycles_p`, default 16: minimum number of cycles `reset_o` must be stable before the next release; must be ≥1.
- `clk_i`  in  1: clock. One clock; every register is on `clk_i`.
- `reset_i`  in  1: reset, synchronous and active-high.
- `req_v_i`  in  `num_channels_p`: per-channel new-request strobe (tag `recv_new_r_o`).
- `req_reset_i`  in  `num_channels_p`: per-channel requested reset value; sampled only where `req_v_i` is 1.
- `reset_o`  out  `num_channels_p`: per-channel reset, active-high, registered.
- `busy_o`  out  1: a release is pending (state WAIT).
- `done_o`  out  1: all `reset_o` bits are 0.

## Operation
- **Request register `req_r[N]`.**
  - Reset value: all ones.
  - On each cycle, for every i with `req_v_i[i]`=1, `req_r[i]` <= `req_reset_i[i]`. Other bits hold.
- **Effective target.** `eff[i]` = OR of `req_r[0..i]` (prefix OR). A channel stays in reset while any upstream channel is requested.
- **Invariant.** `reset_o` is always a thermometer: channels 0..k-1 are 0 and channels k..N-1 are 1, for some 0 ≤ k ≤ N.
- **Assertion.** If any i has `eff[i]`=1 and `reset_o[i]`=0, then on the next edge `reset_o` <= `reset_o` | `eff` (all such bits at once). Assertion has priority over release in the same cycle.
- **Release candidate.** The lowest i with `reset_o[i]`=1 and `eff[i]`=0. At most one channel is released per edge.
- **Hold counter `cnt_r`.**
  - Width is $clog2(hold_cycles_p+1).
  - Reset value: 0.
  - Cleared to 0 on any edge where `reset_o` changes.
  - Otherwise increments, saturating at `hold_cycles_p`.
- **FSM.**
  - STABLE: no pending assertion and no release candidate. Goes to WAIT when a candidate exists.
  - WAIT: a candidate exists.
    - If `cnt_r` == `hold_cycles_p` and no assertion is pending: clear that `reset_o` bit and `cnt_r`. Stay in WAIT if another candidate remains, otherwise go to STABLE.
    - If an assertion is pending: apply it and clear `cnt_r`. Stay in WAIT if a candidate still exists.
    - If the candidate disappears because `req_r` was re-requested: go to STABLE.
- **Outputs.**
  - `busy_o` = (state == WAIT).
  - `done_o` = (`reset_o` == 0).
  - Both are decoded from registers; there is no combinational path from inputs.
- **Boundary cases.**
  - `req_v_i` matching the current `req_r` value: no effect.
  - Re-request of a released channel: that channel and all higher channels re-assert; lower channels are unaffected.
  - `num_channels_p`=1: the prefix OR degenerates to `req_r[0]`.
  - `reset_i` mid-sequence: on the next edge, `req_r` and `reset_o` become all ones, `cnt_r` becomes 0, and the FSM returns to STABLE. Requests presented in the same cycle as `reset_i` are dropped.

## Timing
- **Reset state** (cycle after `reset_i` is sampled high):
  - `reset_o` = all ones
  - `busy_o` = 0
  - `done_o` = 0
  - `cnt_r` = 0
- **Assertion latency.** `req_v_i` high at cycle t → `req_r` updated at t+1 → `reset_o` high at t+2.
- **Release spacing.** `reset_o` stable since an edge at cycle s → release no earlier than cycle s+`hold_cycles_p`+1. Consecutive releases are exactly `hold_cycles_p`+1 cycles apart when uninterrupted.
- **First release from all-ones.** The counter runs from `reset_i` deassertion, so the first release can occur as early as 2 cycles after `req_v_i` if `cnt_r` is already saturated.

## Test plan
- **Reset defaults.** Hold `reset_i` for 3 cycles, then idle 40 cycles → `reset_o`=4'b1111, `busy_o`=0, `done_o`=0 throughout.
- **Full release.** With N=4, H=16 and `cnt_r` saturated, strobe `req_v_i`=4'b1111 with `req_reset_i`=0 at t → `reset_o` 1110 at t+2, 1100 at t+19, 1000 at t+36, 0000 at t+53. `done_o`=1 from t+53; `busy_o`=0 after.
- **Ordering.** Release only channel 2 (`req_reset_i`=0 on bit 2) → `reset_o` stays 1111 and `busy_o` stays 0. Then release channels 0 and 1 → channels are released in order 0, 1, 2, each gap H+1 cycles; channel 3 stays 1.
- **Re-assert mid-sequence.** From `reset_o`=1100, set `req_reset_i[1]`=1 at t → `reset_o`=1110 at t+2 and `cnt_r` cleared. Then release channel 1 again → it drops H+1 cycles after the t+2 edge.
- **Reset mid-sequence.** Raise `reset_i` while `reset_o`=1000 and `busy_o`=1 → next edge gives `reset_o`=1111, `busy_o`=0. A simultaneous `req_v_i` is ignored.
- **Parameter sweep.** Run N=1,H=1 and N=8,H=3 with random strobes → thermometer invariant holds every cycle, and release spacing is never below H+1.
